// File: rtl/ram_controller.sv
// ram_controller: clocked 2^ADDR_W x DATA_W read/write data memory behind a
// req/ack handshake. Each accepted access takes three cycles: accept (IDLE),
// memory operation (ACCESS), completion pulse (ACK).
//
// Optional feature macro: RAM_CLEAR_EN
//   defined   -> after reset a CLEAR sequence zeroes every word, one per cycle,
//                before the first request can be accepted (busy=1 meanwhile).
//   undefined -> reset enters IDLE directly; memory contents start undefined.
//
// Ports:
//   clk       in   clock, rising edge
//   reset     in   asynchronous active-low reset
//   csRAM     in   chip select
//   weRAM     in   1 = write, 0 = read (sampled at acceptance)
//   req       in   level-sensitive access request
//   address   in   CPU address; low ADDR_W bits index the memory
//   data_in   in   write data (sampled at acceptance)
//   ready     out  a request can be accepted this cycle
//   ack       out  one-cycle completion pulse
//   err       out  out-of-range address flag, qualified by ack
//   data_out  out  registered read data, held until the next read completes
//   busy      out  clear sequence running
module ram_controller #(
  parameter int unsigned DATA_W     = 4,
  parameter int unsigned ADDR_W     = 8,
  parameter int unsigned BUS_ADDR_W = 12
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  csRAM,
  input  logic                  weRAM,
  input  logic                  req,
  input  logic [BUS_ADDR_W-1:0] address,
  input  logic [DATA_W-1:0]     data_in,
  output logic                  ready,
  output logic                  ack,
  output logic                  err,
  output logic [DATA_W-1:0]     data_out,
  output logic                  busy
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_ACK    = 2'd2
`ifdef RAM_CLEAR_EN
    ,
    S_CLEAR  = 2'd3
`endif
  } state_t;

`ifdef RAM_CLEAR_EN
  localparam state_t RESET_STATE = S_CLEAR;
`else
  localparam state_t RESET_STATE = S_IDLE;
`endif

  state_t                  state;
  logic [BUS_ADDR_W-1:0]   addr_q;
  logic                    we_q;
  logic [DATA_W-1:0]       wdata_q;
  logic                    oor_q;
  logic [DATA_W-1:0]       mem [DEPTH];

`ifdef RAM_CLEAR_EN
  logic [ADDR_W-1:0]       clr_cnt;
`endif

  logic                    accept_c;
  logic                    oor_c;
  logic [ADDR_W-1:0]       idx_c;

  // Request acceptance and range decode of the latched address
  assign accept_c = (state == S_IDLE) && req && csRAM;
  assign oor_c    = |addr_q[BUS_ADDR_W-1:ADDR_W];
  assign idx_c    = addr_q[ADDR_W-1:0];

  // Control FSM with latched request and registered read data
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= RESET_STATE;
      addr_q   <= '0;
      we_q     <= 1'b0;
      wdata_q  <= '0;
      oor_q    <= 1'b0;
      data_out <= '0;
`ifdef RAM_CLEAR_EN
      clr_cnt  <= '0;
`endif
    end else begin
      case (state)
`ifdef RAM_CLEAR_EN
        S_CLEAR: begin
          clr_cnt <= clr_cnt + ADDR_W'(1);
          if (clr_cnt == '1) begin
            state <= S_IDLE;
          end
        end
`endif
        S_IDLE: begin
          if (accept_c) begin
            addr_q  <= address;
            we_q    <= weRAM;
            wdata_q <= data_in;
            state   <= S_ACCESS;
          end
        end
        S_ACCESS: begin
          oor_q <= oor_c;
          if (!we_q) begin
            data_out <= oor_c ? '0 : mem[idx_c];
          end
          state <= S_ACK;
        end
        S_ACK: begin
          state <= S_IDLE;
        end
        default: begin
          state <= RESET_STATE;
        end
      endcase
    end
  end

  // Storage array; no reset so it maps onto plain memory
  always_ff @(posedge clk) begin
    if ((state == S_ACCESS) && we_q && !oor_c) begin
      mem[idx_c] <= wdata_q;
    end
`ifdef RAM_CLEAR_EN
    else if (state == S_CLEAR) begin
      mem[clr_cnt] <= '0;
    end
`endif
  end

  // Status decoded from state; ready is also held low while reset is asserted
  assign ready = (state == S_IDLE) && reset;
  assign ack   = (state == S_ACK);
  assign err   = (state == S_ACK) && oor_q;
`ifdef RAM_CLEAR_EN
  assign busy  = (state == S_CLEAR);
`else
  assign busy  = 1'b0;
`endif

endmodule

// File: tb/tb_ram_controller.sv
// Testbench for ram_controller: directed scenarios plus randomized accesses
// checked against an array-based reference memory.
module tb_ram_controller;

  logic        clk;
  logic        reset;
  logic        csRAM;
  logic        weRAM;
  logic        req;
  logic [11:0] address;
  logic [3:0]  data_in;
  logic        ready;
  logic        ack;
  logic        err;
  logic [3:0]  data_out;
  logic        busy;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  // Reference memory: value plus "known" flag per word
  logic [3:0] mdl_mem   [256];
  bit         mdl_valid [256];
  logic [3:0] last_rd;
  bit         last_known;

`ifdef RAM_CLEAR_EN
  localparam logic CLEAR_BUILD = 1'b1;
`else
  localparam logic CLEAR_BUILD = 1'b0;
`endif

  ram_controller #(
    .DATA_W    (4),
    .ADDR_W    (8),
    .BUS_ADDR_W(12)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .csRAM   (csRAM),
    .weRAM   (weRAM),
    .req     (req),
    .address (address),
    .data_in (data_in),
    .ready   (ready),
    .ack     (ack),
    .err     (err),
    .data_out(data_out),
    .busy    (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic model_after_reset();
    for (int i = 0; i < 256; i++) begin
      mdl_mem[i]   = 4'h0;
      mdl_valid[i] = CLEAR_BUILD;
    end
    last_rd    = 4'h0;
    last_known = 1'b1;
  endtask

  task automatic wait_ready(input string tag);
    for (int i = 0; i < 400 && ready !== 1'b1; i++) @(negedge clk);
    if (ready !== 1'b1) begin
      errors++;
      $display("FAIL %s_wait_ready: ready=%b expected 1 within bound", tag, ready);
    end
  endtask

  // One complete access; checks phase timing, ack/err and data_out
  task automatic do_access(input logic we, input logic [11:0] a,
                           input logic [3:0] d, input string tag);
    logic       exp_err;
    logic [3:0] exp_d;
    bit         check_d;
    wait_ready(tag);
    req = 1'b1; csRAM = 1'b1; weRAM = we; address = a; data_in = d;
    @(posedge clk);
    @(negedge clk);
    req = 1'b0; csRAM = 1'b0;
    weRAM = 1'($urandom); address = 12'($urandom); data_in = 4'($urandom);
    checks++;
    if (ready !== 1'b0 || ack !== 1'b0) begin
      errors++;
      $display("FAIL %s_access_phase: ready=%b ack=%b expected ready=0 ack=0", tag, ready, ack);
    end
    exp_err = (a[11:8] != 4'h0);
    if (we) begin
      if (!exp_err) begin
        mdl_mem[a[7:0]]   = d;
        mdl_valid[a[7:0]] = 1'b1;
      end
      exp_d   = last_rd;
      check_d = last_known;
    end else begin
      if (exp_err) begin
        exp_d   = 4'h0;
        check_d = 1'b1;
      end else begin
        exp_d   = mdl_mem[a[7:0]];
        check_d = mdl_valid[a[7:0]];
      end
      last_rd    = exp_d;
      last_known = check_d;
    end
    @(negedge clk);
    checks++;
    if (ack !== 1'b1 || err !== exp_err) begin
      errors++;
      $display("FAIL %s_ack: ack=%b err=%b expected ack=1 err=%b", tag, ack, err, exp_err);
    end
    if (check_d) begin
      checks++;
      if (data_out !== exp_d) begin
        errors++;
        $display("FAIL %s_data: data_out=%h expected %h (addr=%h we=%b)", tag, data_out, exp_d, a, we);
      end
    end
    @(negedge clk);
    checks++;
    if (ack !== 1'b0 || ready !== 1'b1) begin
      errors++;
      $display("FAIL %s_post_ack: ack=%b ready=%b expected ack=0 ready=1", tag, ack, ready);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; csRAM = 1'b0; weRAM = 1'b0; req = 1'b0;
    address = 12'h000; data_in = 4'h0;
    #1;
    checks++;
    if (ready !== 1'b0 || ack !== 1'b0 || err !== 1'b0 || data_out !== 4'h0 || busy !== CLEAR_BUILD) begin
      errors++;
      $display("FAIL reset_values: ready=%b ack=%b err=%b data_out=%h busy=%b expected 0 0 0 0 %b",
               ready, ack, err, data_out, busy, CLEAR_BUILD);
    end
    repeat (2) @(negedge clk);
    reset = 1'b1;
    #1;
    checks++;
    if (ready !== !CLEAR_BUILD || busy !== CLEAR_BUILD) begin
      errors++;
      $display("FAIL reset_release: ready=%b busy=%b expected ready=%b busy=%b",
               ready, busy, !CLEAR_BUILD, CLEAR_BUILD);
    end
    model_after_reset();
  endtask

  task automatic test_clear();
`ifdef RAM_CLEAR_EN
    int bad;
    bad = 0;
    req = 1'b1; csRAM = 1'b1; weRAM = 1'b0; address = 12'h000;
    for (int k = 0; k < 256; k++) begin
      if (busy !== 1'b1 || ready !== 1'b0 || ack !== 1'b0) bad++;
      @(negedge clk);
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL clear_busy: %0d cycles out of busy=1/ready=0/ack=0, expected 0", bad);
    end
    checks++;
    if (busy !== 1'b0 || ready !== 1'b1) begin
      errors++;
      $display("FAIL clear_done: busy=%b ready=%b expected busy=0 ready=1", busy, ready);
    end
    req = 1'b0; csRAM = 1'b0;
    do_access(1'b0, 12'h000, 4'h0, "clear_rd000");
    do_access(1'b0, 12'h0FF, 4'h0, "clear_rd0FF");
    do_access(1'b0, 12'h07C, 4'h0, "clear_rd07C");
`endif
  endtask

  task automatic test_write_read();
    do_access(1'b1, 12'h005, 4'hA, "wr005");
    do_access(1'b0, 12'h005, 4'h0, "rd005");
  endtask

  task automatic test_out_of_range();
    do_access(1'b1, 12'h023, 4'h3, "oor_prewr023");
    do_access(1'b1, 12'h123, 4'h7, "oor_wr123");
    do_access(1'b0, 12'h123, 4'h0, "oor_rd123");
    do_access(1'b0, 12'h023, 4'h0, "oor_rd023");
    do_access(1'b0, 12'hF80, 4'h0, "oor_rdF80");
  endtask

  task automatic test_cs_gating();
    int bad;
    bad = 0;
    do_access(1'b1, 12'h010, 4'h4, "cs_prewr");
    wait_ready("cs_gate");
    req = 1'b1; csRAM = 1'b0; weRAM = 1'b1; address = 12'h010; data_in = 4'h9;
    repeat (6) begin
      @(negedge clk);
      if (ready !== 1'b1 || ack !== 1'b0) bad++;
    end
    req = 1'b0;
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL cs_gating: %0d cycles with ready!=1 or ack!=0, expected 0", bad);
    end
    do_access(1'b0, 12'h010, 4'h0, "cs_rd010");
  endtask

  task automatic test_back_to_back();
    int start;
    int ack_cyc [2];
    int n;
    int extra;
    wait_ready("b2b");
    start = cyc;
    n = 0;
    req = 1'b1; csRAM = 1'b1; weRAM = 1'b0; address = 12'h005;
    for (int i = 0; i < 10 && n < 2; i++) begin
      @(negedge clk);
      if (ack === 1'b1) begin
        ack_cyc[n] = cyc;
        n++;
        checks++;
        if (data_out !== mdl_mem[5]) begin
          errors++;
          $display("FAIL b2b_data: data_out=%h expected %h", data_out, mdl_mem[5]);
        end
      end
    end
    req = 1'b0; csRAM = 1'b0;
    last_rd = mdl_mem[5];
    last_known = mdl_valid[5];
    checks++;
    if (n != 2 || ack_cyc[0] != start + 2 || ack_cyc[1] != start + 5) begin
      errors++;
      $display("FAIL b2b_timing: acks=%0d at +%0d/+%0d expected 2 at +2/+5",
               n, ack_cyc[0] - start, ack_cyc[1] - start);
    end
    extra = 0;
    repeat (5) begin
      @(negedge clk);
      if (ack === 1'b1) extra++;
    end
    checks++;
    if (extra != 0) begin
      errors++;
      $display("FAIL b2b_no_third: %0d extra acks expected 0", extra);
    end
  endtask

  task automatic test_wrap();
    do_access(1'b1, 12'h0FF, 4'hF, "wrap_wr0FF");
    do_access(1'b1, 12'h000, 4'h1, "wrap_wr000");
    do_access(1'b0, 12'h0FF, 4'h0, "wrap_rd0FF");
    do_access(1'b0, 12'h000, 4'h0, "wrap_rd000");
  endtask

  task automatic test_random();
    logic        we;
    logic [11:0] a;
    logic [3:0]  d;
    for (int i = 0; i < 40; i++) begin
      we = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 3))
        0:       a = {4'($urandom_range(1, 15)), 8'($urandom)};
        1:       a = {4'h0, 8'($urandom)};
        default: a = {8'h00, 4'($urandom)};
      endcase
      d = 4'($urandom);
      if (!we && a[11:8] == 4'h0 && !mdl_valid[a[7:0]]) we = 1'b1;
      do_access(we, a, d, "rand");
    end
  endtask

  task automatic test_reset_mid_access();
    bit ack_seen;
    do_access(1'b1, 12'h033, 4'h6, "rst_prewr");
    wait_ready("rst_mid");
    req = 1'b1; csRAM = 1'b1; weRAM = 1'b0; address = 12'h033;
    @(posedge clk);
    #1;
    reset = 1'b0; req = 1'b0; csRAM = 1'b0;
    #1;
    checks++;
    if (ack !== 1'b0 || data_out !== 4'h0 || ready !== 1'b0 || busy !== CLEAR_BUILD) begin
      errors++;
      $display("FAIL rst_mid_values: ack=%b data_out=%h ready=%b busy=%b expected 0 0 0 %b",
               ack, data_out, ready, busy, CLEAR_BUILD);
    end
    ack_seen = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (ack === 1'b1) ack_seen = 1'b1;
    end
    reset = 1'b1;
    #1;
    checks++;
    if (busy !== CLEAR_BUILD || ready !== !CLEAR_BUILD) begin
      errors++;
      $display("FAIL rst_mid_release: busy=%b ready=%b expected busy=%b ready=%b",
               busy, ready, CLEAR_BUILD, !CLEAR_BUILD);
    end
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (ack === 1'b1) ack_seen = 1'b1;
    end
    checks++;
    if (ack_seen || ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_recover: ack_seen=%b ready=%b busy=%b expected 0 1 0",
               ack_seen, ready, busy);
    end
    model_after_reset();
    do_access(1'b0, 12'h033, 4'h0, "rst_rd033");
    do_access(1'b1, 12'h044, 4'hC, "rst_wr044");
    do_access(1'b0, 12'h044, 4'h0, "rst_rd044");
  endtask

  initial begin
    test_reset();
    test_clear();
    test_write_read();
    test_out_of_range();
    test_cs_gating();
    test_back_to_back();
    test_wrap();
    test_random();
    test_reset_mid_access();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
